// File: rtl/beamformer_pkg.sv
// Shared types for the beamformer signal path: RAM geometry,
// sequencer state encoding and the sample bundle.
package beamformer_pkg;

  localparam int SIG_ADDR_W     = 11;
  localparam int SIG_DATA_W     = 32;
  localparam int SAMPLE_INDEX_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic [SIG_DATA_W-1:0]     value;
    logic [SAMPLE_INDEX_W-1:0] index;
    logic                      last;
  } sample_t;

endpackage

// File: rtl/sample_skid_fifo.sv
// Small synchronous FIFO of sample_t; head is read combinationally.
// Storage is cleared on reset so an idle head presents zeros.
module sample_skid_fifo
  import beamformer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  sample_t       wdata,
  input  logic          pop,
  output sample_t       rdata,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  sample_t       mem_q [DEPTH];
  sample_t       mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    if (push) begin
      mem_d[wr_q] = wdata;
      wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
    end
    if (pop) begin
      rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/bram_sample_sequencer.sv
// Signal-RAM reader feeding the beamformer as a valid/ready sample stream.
// Define SEQ_CONTINUOUS_EN to chain frames back-to-back while start is held.
module bram_sample_sequencer
  import beamformer_pkg::*;
#(
  parameter int ADDR_W      = SIG_ADDR_W,
  parameter int DATA_W      = SIG_DATA_W,
  parameter int INDEX_W     = SAMPLE_INDEX_W,
  parameter int NUM_SAMPLES = 2048,
  parameter int RAM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  ram_address,
  output logic               ram_rden,
  input  logic [DATA_W-1:0]  ram_q,
  output logic [DATA_W-1:0]  sample_value,
  output logic [INDEX_W-1:0] sample_index,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               frame_last
);

  localparam int IFW = $clog2(RAM_LATENCY + 1);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);

  seq_state_t             state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [INDEX_W-1:0]     idx_q, idx_d;
  logic [RAM_LATENCY-1:0] vld_q, vld_d;
  logic [RAM_LATENCY-1:0] plast_q, plast_d;
  logic [INDEX_W-1:0]     pidx_q [RAM_LATENCY];
  logic [INDEX_W-1:0]     pidx_d [RAM_LATENCY];

  logic [IFW-1:0] in_flight;
  logic [CW-1:0]  fifo_count;
  logic           fifo_empty;
  logic           fifo_full;
  logic           rden;
  logic           tap;
  logic           pop;
  logic           final_pop;
  sample_t        wr;
  sample_t        head;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RAM_LATENCY; i++) begin
      in_flight = in_flight + IFW'(vld_q[i]);
    end
  end

  // Reads in flight plus queued samples never exceed the FIFO space.
  assign rden = (state_q == READ) &&
                (int'(in_flight) + int'(fifo_count) < FIFO_DEPTH);
  assign tap  = vld_q[RAM_LATENCY-1];
  assign pop  = !fifo_empty && sample_ready;
  assign final_pop = pop && head.last && (in_flight == '0) &&
                     (fifo_count == CW'(1));

  always_comb begin
    vld_d[0]   = rden;
    plast_d[0] = (addr_q == LAST_ADDR);
    pidx_d[0]  = idx_q;
    for (int i = 1; i < RAM_LATENCY; i++) begin
      vld_d[i]   = vld_q[i-1];
      plast_d[i] = plast_q[i-1];
      pidx_d[i]  = pidx_q[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    if (rden) begin
      addr_d = addr_q + ADDR_W'(1);
      idx_d  = idx_q + INDEX_W'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          addr_d  = '0;
          idx_d   = '0;
        end
      end
      READ: begin
        if (rden && (addr_q == LAST_ADDR)) begin
`ifdef SEQ_CONTINUOUS_EN
          if (start) addr_d = '0;
          else state_d = DRAIN;
`else
          state_d = DRAIN;
`endif
        end
      end
      DRAIN: begin
        if (final_pop) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      vld_q   <= '0;
      plast_q <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) pidx_q[i] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      plast_q <= plast_d;
      pidx_q  <= pidx_d;
    end
  end

  always_comb begin
    wr       = '0;
    wr.value = SIG_DATA_W'(ram_q);
    wr.index = SAMPLE_INDEX_W'(pidx_q[RAM_LATENCY-1]);
    wr.last  = plast_q[RAM_LATENCY-1];
  end

  sample_skid_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (tap && !fifo_full),
    .wdata(wr),
    .pop  (pop),
    .rdata(head),
    .count(fifo_count),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  assign busy         = (state_q == READ) || (state_q == DRAIN);
  assign done         = (state_q == DONE);
  assign ram_address  = addr_q;
  assign ram_rden     = rden;
  assign sample_value = DATA_W'(head.value);
  assign sample_index = INDEX_W'(head.index);
  assign frame_last   = head.last;
  assign sample_valid = !fifo_empty;

endmodule

// File: doc/bram_sample_sequencer.md
Name: bram_sample_sequencer

Overview:
- Upstream feeder for the delay beamformer.
- Sequences read addresses into the single-port signal RAM (11-bit address, 32-bit q, fixed read latency) and retimes the returned words into a valid/ready sample stream.
- Each output sample carries a running sample index, which becomes the beamformer's input_value / input_index pair.
- Absorbs RAM read latency and downstream backpressure through an internal credit-controlled skid FIFO.

Parameters:
- ADDR_W, 11: RAM address width.
- DATA_W, 32: sample word width.
- INDEX_W, 16: sample index width.
- NUM_SAMPLES, 2048: samples per frame; must satisfy 1 <= NUM_SAMPLES <= 2**ADDR_W.
- RAM_LATENCY, 2: cycles from ram_address to valid ram_q; must be 1..4.
- FIFO_DEPTH, 4: skid FIFO entries; must be >= RAM_LATENCY+1.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous active-high reset.
- start, input, 1: frame request, sampled in IDLE.
- busy, output, 1: high from accepted start until done.
- done, output, 1: one-cycle pulse after the final sample handshake.
- ram_address, output, ADDR_W: read address to signal RAM.
- ram_rden, output, 1: read enable; one RAM read per high cycle.
- ram_q, input, DATA_W: RAM read data, valid RAM_LATENCY cycles after ram_rden.
- sample_value, output, DATA_W: sample to beamformer.
- sample_index, output, INDEX_W: index of sample_value.
- sample_valid, output, 1: sample_value/sample_index valid.
- sample_ready, input, 1: downstream accepts; transfer occurs when sample_valid && sample_ready.
- frame_last, output, 1: qualifies the final sample of a frame; meaningful only with sample_valid.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - All outputs go to 0: busy, done, ram_address, ram_rden, sample_value, sample_index, sample_valid, frame_last.
  - FSM returns to IDLE.
  - FIFO empties; in-flight reads are discarded via the flushed latency shift register.
  - Reset mid-frame aborts the frame with no done pulse.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: start=1 -> READ; busy=1 next cycle; issue counter and index counter cleared to 0.
  - READ: ram_rden=1 when (in_flight + fifo_count) < FIFO_DEPTH, otherwise 0. Each issued read increments ram_address. After issuing address NUM_SAMPLES-1 -> DRAIN.
  - DRAIN: no reads issued. Go to DONE on the cycle the frame_last sample is transferred.
  - DONE: done=1 for exactly one cycle; busy=0 that cycle; -> IDLE.
  - start outside IDLE is ignored. start held high in IDLE after DONE begins a new frame (one idle cycle between frames).
- Read pipeline:
  - A RAM_LATENCY-deep valid shift register tracks ram_rden.
  - Its tap writes ram_q into the FIFO, together with that read's index and last flag.
  - The credit check guarantees the FIFO never overflows; overflow is a bench assertion.
- Output:
  - FIFO head drives sample_value, sample_index and frame_last directly.
  - sample_valid = FIFO not empty.
  - Holding: while sample_valid && !sample_ready, all output fields are held stable.
  - Simultaneous push and pop on the same cycle is legal; the count is unchanged.
- Latency: first sample_valid appears RAM_LATENCY+1 cycles after the start edge. Throughput is 1 sample/cycle while sample_ready is held high.
- Indices:
  - sample_index = 0..NUM_SAMPLES-1 within the frame, zero-extended from the address.
  - ram_address wraps to 0 after 2**ADDR_W-1; this is reachable only with NUM_SAMPLES = 2**ADDR_W.
- Counters:
  - in_flight is the popcount of the latency shift register, computed as a $clog2(RAM_LATENCY+1)-bit quantity.
  - fifo_count is $clog2(FIFO_DEPTH+1) bits.

Optional Feature:
- Macro: SEQ_CONTINUOUS_EN.
- Defined:
  - At the end of a frame, if start=1 the FSM skips DONE/IDLE and goes READ -> READ: ram_address wraps to 0 and no bubble is inserted.
  - sample_index keeps incrementing modulo 2**INDEX_W across frames and does not reset per frame.
  - frame_last still marks every frame end.
  - done pulses only when the last frame ends with start=0.
- Undefined: single-frame behaviour as above; sample_index restarts at 0 each frame.

Decomposition:
- Shared package beamformer_pkg holds:
  - Constants: SIG_ADDR_W=11, SIG_DATA_W=32, SAMPLE_INDEX_W=16.
  - Typedef seq_state_t, enum {IDLE, READ, DRAIN, DONE}.
  - Typedef sample_t, a struct of value, index and last.
- One sub-module: sample_skid_fifo, a parameterized synchronous FIFO of sample_t with push, pop, count, empty and full.

Test Plan:
- Reset, then start pulse, sample_ready=1, NUM_SAMPLES=8, ram_q=addr*3 -> samples 0,3,...,21 with indices 0..7; first valid at cycle 3 after start; frame_last on index 7; done one cycle after that transfer.
- sample_ready toggling 1,0,0,1 repeating, NUM_SAMPLES=16 -> all 16 samples in order, none lost or duplicated; fields stable while stalled; FIFO never overflows.
- sample_ready=0 for 20 cycles after start -> ram_rden issues exactly FIFO_DEPTH reads, then stays 0 until ready rises.
- rst asserted at sample index 5 of a 16-sample frame -> next cycle all outputs 0 and no done; a fresh start restarts from index 0.
- start pulsed again at cycles 2 and 5 of a running frame -> ignored; exactly one frame and one done.
- With SEQ_CONTINUOUS_EN, start held high, NUM_SAMPLES=4 -> indices 0..11 continuous, frame_last on indices 3, 7 and 11; after start drops, done pulses once at the frame end.
